// File: rtl/uart_frame_tx_if.sv
// Handshake bundle for uart_frame_tx: sample-word capture side and byte stream to the UART.
// The master modport is the transmitter's view; slave is the source/sink side.
interface uart_frame_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] signal;
  logic              signal_valid;
  logic              signal_ready;
  logic [7:0]        to_uart_data;
  logic              to_uart_valid;
  logic              to_uart_ready;
  logic              to_uart_error;

  modport master (
    input  signal, signal_valid, to_uart_ready,
    output signal_ready, to_uart_data, to_uart_valid, to_uart_error
  );

  modport slave (
    output signal, signal_valid, to_uart_ready,
    input  signal_ready, to_uart_data, to_uart_valid, to_uart_error
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Framed packet transmitter: SOM, payload MSB-first, optional checksum, EOM, per-byte valid/ready.
// Optional checksum byte enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_tx #(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SOM_BYTE      = 8'h73,
  parameter logic [7:0] EOM_BYTE      = 8'h65,
  parameter int         COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_frame_tx_if.master    bus,
  input  logic               continuous,
  output logic               busy,
  output logic [COUNT_W-1:0] frame_count
);
  localparam int DATA_W = 8 * PAYLOAD_BYTES;
  localparam int IDX_W  = $clog2(PAYLOAD_BYTES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SOM     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd3;
`endif
  localparam logic [2:0] S_EOM     = 3'd4;

  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_capture;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_busy;
  logic [COUNT_W-1:0] r_count;

  logic               w_capture;
  logic               w_xfer;
  logic [7:0]         w_next_byte;
  logic               w_more;

  assign bus.signal_ready  = (r_state == S_IDLE);
  assign bus.to_uart_data  = r_data;
  assign bus.to_uart_valid = r_valid;
  assign bus.to_uart_error = 1'b0;
  assign busy              = r_busy;
  assign frame_count       = r_count;

  assign w_capture = (r_state == S_IDLE) && (bus.signal_valid || continuous);
  assign w_xfer    = r_valid && bus.to_uart_ready;
  assign w_more    = (r_idx < IDX_W'(PAYLOAD_BYTES));

  // r_idx counts bytes already loaded; it selects the next byte down from the MSB.
  always_comb begin
    w_next_byte = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      if (IDX_W'(i) == r_idx) w_next_byte = r_capture[DATA_W-1-8*i -: 8];
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] w_chk;

  always_comb begin
    w_chk = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      w_chk = w_chk + r_capture[8*i +: 8];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_capture <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_capture <= bus.signal;
            r_data    <= SOM_BYTE;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SOM;
          end
        end
        S_SOM: begin
          if (w_xfer) begin
            r_data  <= r_capture[DATA_W-1 -: 8];
            r_idx   <= IDX_W'(1);
            r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            if (w_more) begin
              r_data <= w_next_byte;
              r_idx  <= r_idx + 1'b1;
            end else begin
`ifdef UART_FRAME_CHECKSUM_EN
              r_data  <= w_chk;
              r_state <= S_CHK;
`else
              r_data  <= EOM_BYTE;
              r_state <= S_EOM;
`endif
            end
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_data  <= EOM_BYTE;
            r_state <= S_EOM;
          end
        end
`endif
        S_EOM: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= r_count + 1'b1;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed self-checking bench for uart_frame_tx: 4-byte instance (2-bit frame counter) and 1-byte instance.
module tb_uart_frame_tx;
  localparam int PB = 4;
  localparam int CW = 2;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int L  = PB + 3;
  localparam int LB = 4;
`else
  localparam int L  = PB + 2;
  localparam int LB = 3;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cont_a, cont_b;
  logic          busy_a, busy_b;
  logic [CW-1:0] fc_a;
  logic [15:0]   fc_b;

  always #5 clk = ~clk;

  uart_frame_tx_if #(.DATA_W(32)) bus_a ();
  uart_frame_tx_if #(.DATA_W(8))  bus_b ();

  uart_frame_tx #(.PAYLOAD_BYTES(PB), .COUNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .continuous(cont_a),
    .busy(busy_a), .frame_count(fc_a)
  );

  uart_frame_tx #(.PAYLOAD_BYTES(1), .COUNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .continuous(cont_b),
    .busy(busy_b), .frame_count(fc_b)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_1234 [L];
  logic [7:0] exp_cafe [L];
  logic [7:0] exp_a5   [LB];

  logic [7:0] got [$];
  int stall_bad, sr_bad, used_cycles;
  bit timed_out;

  // Collects bytes accepted by dut_a until valid drops after at least one byte.
  task automatic collect(input int budget, input bit toggle, input logic [31:0] sig_after);
    int cyc, phase;
    bit stalled;
    logic [7:0] held;
    got.delete();
    stall_bad = 0; sr_bad = 0; timed_out = 0;
    cyc = 0; phase = 0; stalled = 0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus_a.signal_valid = 1'b0;
        bus_a.signal       = sig_after;
      end
      if (stalled && bus_a.to_uart_data !== held) stall_bad++;
      if (bus_a.to_uart_valid && bus_a.signal_ready) sr_bad++;
      if (!bus_a.to_uart_valid && got.size() > 0) break;
      if (cyc > budget) begin
        timed_out = 1;
        break;
      end
      bus_a.to_uart_ready = toggle ? (phase % 3 == 0) : 1'b1;
      phase++;
      stalled = bus_a.to_uart_valid && !bus_a.to_uart_ready;
      held    = bus_a.to_uart_data;
      if (bus_a.to_uart_valid && bus_a.to_uart_ready) got.push_back(bus_a.to_uart_data);
    end
    used_cycles = cyc;
  endtask

  task automatic apply_reset();
    bus_a.signal_valid = 1'b0; cont_a = 1'b0;
    bus_b.signal_valid = 1'b0; cont_b = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    cont_a = 1'b1; bus_a.signal_valid = 1'b1; bus_a.to_uart_ready = 1'b1;
    bus_a.signal = 32'h12345678;
    cont_b = 1'b1; bus_b.signal_valid = 1'b1; bus_b.to_uart_ready = 1'b1;
    bus_b.signal = 8'h5A;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (busy_a !== 1'b1 || fc_a !== 2'd1) begin
      errors++;
      $display("FAIL reset_pre busy=%b count=%0d want busy=1 count=1", busy_a, fc_a);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_a.to_uart_valid !== 1'b0 || bus_a.to_uart_data !== 8'h00 || busy_a !== 1'b0 || fc_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_async_a valid=%b data=%h busy=%b count=%0d want all 0",
               bus_a.to_uart_valid, bus_a.to_uart_data, busy_a, fc_a);
    end
    checks++;
    if (bus_a.signal_ready !== 1'b1 || bus_a.to_uart_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_a ready=%b err=%b want ready=1 err=0", bus_a.signal_ready, bus_a.to_uart_error);
    end
    checks++;
    if (bus_b.to_uart_valid !== 1'b0 || busy_b !== 1'b0 || fc_b !== 16'd0 || bus_b.signal_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_b valid=%b busy=%b count=%0d ready=%b want 0,0,0,1",
               bus_b.to_uart_valid, busy_b, fc_b, bus_b.signal_ready);
    end
    bus_a.signal_valid = 1'b0; cont_a = 1'b0;
    bus_b.signal_valid = 1'b0; cont_b = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_frame();
    @(negedge clk);
    bus_a.signal = 32'h12345678; bus_a.signal_valid = 1'b1; bus_a.to_uart_ready = 1'b1;
    checks++;
    if (bus_a.signal_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_idle_ready got %b want 1", bus_a.signal_ready);
    end
    collect(40, 1'b0, 32'h12345678);
    checks++;
    if (timed_out || got.size() != L) begin
      errors++;
      $display("FAIL frame_len got %0d bytes timeout=%0d want %0d", got.size(), timed_out, L);
    end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_1234[i]) begin
        errors++;
        $display("FAIL frame_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_1234[i]);
      end
    end
    checks++;
    if (used_cycles != L + 1) begin
      errors++;
      $display("FAIL frame_cycles got %0d want %0d", used_cycles, L + 1);
    end
    checks++;
    if (sr_bad != 0) begin
      errors++;
      $display("FAIL frame_sig_ready_busy got %0d want 0", sr_bad);
    end
    checks++;
    if (fc_a !== 2'd1 || bus_a.to_uart_valid !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL frame_end count=%0d valid=%b busy=%b want 1,0,0", fc_a, bus_a.to_uart_valid, busy_a);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus_a.signal = 32'h12345678; bus_a.signal_valid = 1'b1; bus_a.to_uart_ready = 1'b0;
    collect(80, 1'b1, 32'hDEADBEEF);
    checks++;
    if (timed_out || got.size() != L) begin
      errors++;
      $display("FAIL stall_len got %0d bytes timeout=%0d want %0d", got.size(), timed_out, L);
    end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_1234[i]) begin
        errors++;
        $display("FAIL stall_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_1234[i]);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d changes want 0", stall_bad);
    end
    checks++;
    if (fc_a !== 2'd2) begin
      errors++;
      $display("FAIL stall_count got %0d want 2", fc_a);
    end
  endtask

  task automatic test_continuous();
    apply_reset();
    bus_a.signal = 32'h12345678; bus_a.to_uart_ready = 1'b1; cont_a = 1'b1;
    for (int i = 0; i <= 4 * (L + 1); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus_a.to_uart_valid !== (i % (L + 1) != 0)) begin
        errors++;
        $display("FAIL cont_valid@%0d got %b want %b", i, bus_a.to_uart_valid, (i % (L + 1) != 0));
      end
      if (i % (L + 1) == 0) begin
        checks++;
        if (fc_a !== CW'((i / (L + 1)) % 4)) begin
          errors++;
          $display("FAIL cont_count@%0d got %0d want %0d", i, fc_a, (i / (L + 1)) % 4);
        end
      end
      if (i == 4 * (L + 1)) cont_a = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    @(negedge clk);
    bus_a.signal = 32'h12345678; bus_a.signal_valid = 1'b1; bus_a.to_uart_ready = 1'b1;
    @(negedge clk); bus_a.signal_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (bus_a.to_uart_valid !== 1'b1 || bus_a.to_uart_data !== 8'h56) begin
      errors++;
      $display("FAIL mid_pre valid=%b data=%h want 1,56", bus_a.to_uart_valid, bus_a.to_uart_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_a.to_uart_valid !== 1'b0 || fc_a !== 2'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset valid=%b count=%0d busy=%b want 0,0,0", bus_a.to_uart_valid, fc_a, busy_a);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    bus_a.signal = 32'hCAFEF00D; bus_a.signal_valid = 1'b1;
    collect(40, 1'b0, 32'hCAFEF00D);
    checks++;
    if (timed_out || got.size() != L) begin
      errors++;
      $display("FAIL mid_len got %0d bytes timeout=%0d want %0d", got.size(), timed_out, L);
    end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_cafe[i]) begin
        errors++;
        $display("FAIL mid_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_cafe[i]);
      end
    end
    checks++;
    if (fc_a !== 2'd1) begin
      errors++;
      $display("FAIL mid_count got %0d want 1", fc_a);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] gb [$];
    int cyc;
    @(negedge clk);
    bus_b.signal = 8'hA5; bus_b.signal_valid = 1'b1; bus_b.to_uart_ready = 1'b1;
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      bus_b.signal_valid = 1'b0;
      if (!bus_b.to_uart_valid && gb.size() > 0) break;
      if (bus_b.to_uart_valid) gb.push_back(bus_b.to_uart_data);
    end
    checks++;
    if (gb.size() != LB) begin
      errors++;
      $display("FAIL single_len got %0d want %0d", gb.size(), LB);
    end
    for (int i = 0; i < LB; i++) begin
      checks++;
      if (i >= gb.size() || gb[i] !== exp_a5[i]) begin
        errors++;
        $display("FAIL single_byte%0d got %h want %h", i, (i < gb.size()) ? gb[i] : 8'hxx, exp_a5[i]);
      end
    end
    checks++;
    if (fc_b !== 16'd1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", fc_b);
    end
  endtask

  initial begin
`ifdef UART_FRAME_CHECKSUM_EN
    exp_1234 = '{8'h73, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14, 8'h65};
    exp_cafe = '{8'h73, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC5, 8'h65};
    exp_a5   = '{8'h73, 8'hA5, 8'hA5, 8'h65};
`else
    exp_1234 = '{8'h73, 8'h12, 8'h34, 8'h56, 8'h78, 8'h65};
    exp_cafe = '{8'h73, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h65};
    exp_a5   = '{8'h73, 8'hA5, 8'h65};
`endif
    reset = 1'b0;
    cont_a = 1'b0; cont_b = 1'b0;
    bus_a.signal = '0; bus_a.signal_valid = 1'b0; bus_a.to_uart_ready = 1'b0;
    bus_b.signal = '0; bus_b.signal_valid = 1'b0; bus_b.to_uart_ready = 1'b0;
    repeat (2) @(negedge clk);

    test_reset();
    test_frame();
    test_stall();
    test_continuous();
    test_reset_midframe();
    test_single_byte();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
